// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, instruction field positions, reset PC.
package mips_pkg;
    typedef enum logic {IDLE, BUSY} fetch_state_t;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int JUMP_IDX_W = 26;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/flopenr.sv
// Enable register with synchronous active-low reset to a parameterised value.
module flopenr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (!reset)  q <= RESET_VAL;
        else if (en) q <= d;
    end
endmodule

// File: rtl/fetch_unit.sv
// Multicycle fetch / memory-interface stage: PC, IR, MDR and a req/ready memory
// handshake that stalls the controller while an access is outstanding.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
    parameter int               TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcen,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic             iord,
    input  logic             irwrite,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] aluresult,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] writedata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             stall,
    output logic             bus_err,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] data,
    output logic [5:0]       op,
    output logic [5:0]       funct
);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    fetch_state_t     state, state_nxt;
    logic [7:0]       cnt;
    logic             access, done, timeout;
    logic [WIDTH-1:0] rd, pc_nxt;

    assign access    = irwrite | iord;
    assign mem_addr  = iord ? aluout : pc;
    assign mem_wdata = writedata;
    assign mem_we    = iord & memwrite & mem_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)   cnt <= '0;
            else if (!mem_ready) cnt <= cnt + 8'd1;
            if (timeout)         bus_err <= 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held so memory sees no request.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        if (reset) begin
            case (state)
                IDLE: if (access) begin
                    mem_req   = 1'b1;
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end
                BUSY: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == TO_LIM) begin
                        done      = 1'b1;
                        timeout   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rd     = timeout ? '0 : mem_rdata;
    assign pc_nxt = jump  ? {pc[WIDTH-1:WIDTH-4], instr[JUMP_IDX_W-1:0], 2'b00}
                  : pcsrc ? aluout : aluresult;

    flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .en(pcen & ~stall), .d(pc_nxt), .q(pc)
    );
    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
        .clk(clk), .reset(reset), .en(done & irwrite), .d(rd), .q(instr)
    );
    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
        .clk(clk), .reset(reset), .en(done & iord & ~memwrite), .d(rd), .q(data)
    );

    assign op    = instr[OP_MSB:OP_LSB];
    assign funct = instr[FUNCT_MSB:FUNCT_LSB];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven and outputs checked on the falling edge.
module tb_fetch_unit;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcen, pcsrc, jump, iord, irwrite, memwrite;
    logic [31:0] aluresult, aluout, writedata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, stall, bus_err;
    logic [31:0] pc, instr, data;
    logic [5:0]  op, funct;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .pcen(pcen), .pcsrc(pcsrc), .jump(jump),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .aluresult(aluresult), .aluout(aluout), .writedata(writedata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .bus_err(bus_err), .pc(pc), .instr(instr), .data(data),
        .op(op), .funct(funct)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle_ctl();
        pcen = 0; pcsrc = 0; jump = 0; iord = 0; irwrite = 0; memwrite = 0;
        mem_ready = 0;
    endtask

    initial begin
        int cyc;
        reset = 0; idle_ctl();
        aluresult = '0; aluout = '0; writedata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);

        // reset state, outputs forced low even with a pending fetch
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", instr, 32'h0);
        chk("rst_mdr", data, 32'h0);
        chk("rst_buserr", {31'b0, bus_err}, 32'h0);
        irwrite = 1; #1;
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        irwrite = 0;
        @(negedge clk); reset = 1;

        // fetch, ready on first BUSY cycle
        irwrite = 1; pcen = 1; aluresult = 32'h4; #1;
        chk("f1_addr", mem_addr, 32'h0);
        chk("f1_req", {31'b0, mem_req}, 32'h1);
        chk("f1_stall_issue", {31'b0, stall}, 32'h1);
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h8C01_0004; #1;
        chk("f1_stall_done", {31'b0, stall}, 32'h0);
        @(negedge clk);
        chk("f1_ir", instr, 32'h8C01_0004);
        chk("f1_op", {26'b0, op}, 32'h23);
        chk("f1_pc", pc, 32'h4);
        idle_ctl(); #1;
        chk("f1_idle_req", {31'b0, mem_req}, 32'h0);
        mem_ready = 1; #1;  // ready in IDLE must be ignored
        chk("idle_ready_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        chk("idle_ready_ir", instr, 32'h8C01_0004);
        mem_ready = 0;

        // fetch with 3-cycle ready delay: stall high 4 cycles
        irwrite = 1; pcen = 1; aluresult = 32'h8; mem_rdata = 32'h2002_0005;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("f2_stall%0d", i), {31'b0, stall}, 32'h1);
            chk($sformatf("f2_addr%0d", i), mem_addr, 32'h4);
            chk($sformatf("f2_pc%0d", i), pc, 32'h4);
            chk($sformatf("f2_ir%0d", i), instr, 32'h8C01_0004);
            @(negedge clk);
        end
        mem_ready = 1; #1;
        chk("f2_stall_done", {31'b0, stall}, 32'h0);
        @(negedge clk);
        chk("f2_ir", instr, 32'h2002_0005);
        chk("f2_op", {26'b0, op}, 32'h08);
        chk("f2_pc", pc, 32'h8);
        idle_ctl();

        // load
        iord = 1; aluout = 32'h40; #1;
        chk("ld_addr", mem_addr, 32'h40);
        chk("ld_we", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("ld_we_busy", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        chk("ld_mdr", data, 32'hDEAD_BEEF);
        chk("ld_ir", instr, 32'h2002_0005);
        chk("ld_pc", pc, 32'h8);
        idle_ctl();

        // store
        iord = 1; memwrite = 1; aluout = 32'h44; writedata = 32'h1234_5678; #1;
        chk("st_we", {31'b0, mem_we}, 32'h1);
        chk("st_wdata", mem_wdata, 32'h1234_5678);
        chk("st_addr", mem_addr, 32'h44);
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("st_mdr", data, 32'hDEAD_BEEF);
        chk("st_ir", instr, 32'h2002_0005);
        idle_ctl(); #1;
        chk("st_we_idle", {31'b0, mem_we}, 32'h0);

        // load PC from aluout, fetch a j instruction, then take the jump
        pcen = 1; pcsrc = 1; aluout = 32'h1000_0008; #1;
        chk("br_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        chk("br_pc", pc, 32'h1000_0008);
        idle_ctl();
        irwrite = 1; @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h0800_0010;
        @(negedge clk);
        chk("j_ir", instr, 32'h0800_0010);
        chk("j_pc_hold", pc, 32'h1000_0008);
        idle_ctl();
        pcen = 1; jump = 1; aluresult = 32'h0; #1;
        chk("j_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        chk("j_pc", pc, 32'h1000_0040);
        idle_ctl();

        // memory never ready: timeout forces completion with zero data
        irwrite = 1;
        cyc = 0; #1;
        while (stall && cyc < TIMEOUT + 10) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("to_stall_ok", {31'b0, (cyc >= TIMEOUT) && (cyc <= TIMEOUT + 1)}, 32'h1);
        @(negedge clk);
        chk("to_ir", instr, 32'h0);
        chk("to_buserr", {31'b0, bus_err}, 32'h1);
        chk("to_pc", pc, 32'h1000_0040);
        idle_ctl();
        irwrite = 1; @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h0000_0020;
        @(negedge clk);
        chk("to2_funct", {26'b0, funct}, 32'h20);
        chk("to2_buserr_sticky", {31'b0, bus_err}, 32'h1);
        idle_ctl();

        // reset mid-BUSY abandons the access
        irwrite = 1; pcen = 1; aluresult = 32'h44; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        reset = 0; #1;
        chk("rb_req", {31'b0, mem_req}, 32'h0);
        chk("rb_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        reset = 1; idle_ctl(); mem_ready = 1; #1;
        chk("rb_req_after", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        chk("rb_pc", pc, 32'h0);
        chk("rb_ir", instr, 32'h0);
        chk("rb_buserr", {31'b0, bus_err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
